regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the current register unit. It is a multi-port GPR file with a counting pending-writeback scoreboard, same-cycle writeback bypass and a valid/ready output stage. It sits between decode and the execution units: it reads source operands, reserves destination registers, stalls decode on hazards, and accepts writebacks from NUM_WB completion ports.

Parameters:
DATA_W, 64, register/operand width
REG_W, 5, register address width
NUM_REGS, 2**REG_W, architectural registers
NUM_RD, 3, source operand ports
NUM_DST, 2, destination reservations per issue
NUM_WB, 2, writeback ports
PEND_W, 2, pending-count width (max 2**PEND_W-1 writes in flight per register)
TAG_W, 32, opaque pass-through bundle (opcode, xopcode, format, imm, address bits)

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
issue_valid_i  in  1  decode presents an instruction
issue_ready_o  out  1  instruction accepted this cycle; stall = valid & !ready
rd_en_i  in  NUM_RD  source port enabled
rd_addr_i  in  NUM_RD*REG_W  source register addresses
rd_zero_i  in  NUM_RD  "value-or-zero": address 0 reads as 0 with no hazard check
rd_imm_i  in  NUM_RD  field is immediate: operand = zero-extended address, no hazard check
dst_en_i  in  NUM_DST  destination reservation enabled
dst_addr_i  in  NUM_DST*REG_W  destination register addresses
tag_i  in  TAG_W  pass-through bundle
out_valid_o  out  1  operand bundle valid
out_ready_i  in  1  downstream accepts the bundle
operand_o  out  NUM_RD*DATA_W  resolved operands
operand_en_o  out  NUM_RD  copy of rd_en_i
dst_en_o  out  NUM_DST  copy of dst_en_i
dst_addr_o  out  NUM_DST*REG_W  copy of dst_addr_i
tag_o  out  TAG_W  copy of tag_i
wb_en_i  in  NUM_WB  writeback strobe
wb_addr_i  in  NUM_WB*REG_W  writeback address
wb_data_i  in  NUM_WB*DATA_W  writeback data
wb_err_o  out  1  sticky: a writeback hit a register with pending count 0

Behaviour:
- Reset (asynchronous): all registers and pending counts = 0; out_valid_o, wb_err_o, operand_o, operand_en_o, dst_en_o, dst_addr_o, tag_o = 0. issue_ready_o is combinational and reads 1 after reset.
- Source p is "checked" when rd_en_i[p] & !rd_imm_i[p] & !(rd_zero_i[p] & addr==0).
- Source p is hazarded when it is checked and pending[addr] > 0. Exception: pending[addr]==1 and a writeback to addr arrives this cycle; the source is then bypassed.
- Destination overflow: pending[a] plus the number of enabled dst ports naming a, minus this cycle's writebacks to a, exceeds 2**PEND_W-1.
- issue_ready_o = !any hazard & !overflow & (!out_valid_o | out_ready_i). This is purely combinational from the inputs and state.
- Accept (issue_valid_i & issue_ready_o): at the next edge, out_valid_o=1 and outputs are registered. Latency is 1 cycle.
- Operand priority: immediate, then zero, then bypass data (highest-index wb port that matches), then regFile.
- Output hold: while out_valid_o & !out_ready_i, all outputs are stable.
- out_valid_o clears when it is consumed without a new accept.
- Pending count per register: new = old + (#accepted dst naming it) - (#wb_en naming it). It saturates at 0. Wrapping must never occur; the overflow stall guarantees this.
- Read-before-reserve: a source equal to a destination of the same instruction reads the pre-issue value. That source is checked against the old count only.
- Writebacks are independent of issue and apply every cycle. If two wb ports name the same register, the higher index wins the data and both decrement the count.
- A writeback to a register whose count is 0 still writes the data, leaves the count at 0, and sets wb_err_o. wb_err_o clears only on reset.
- Register 0 is an ordinary register. Only rd_zero_i gives it zero semantics.

Decomposition:
- Package regfile_pkg holds DATA_W/REG_W/PEND_W defaults, the pending-count typedef, and the operand-select encoding (IMM, ZERO, BYPASS, FILE).
- Sub-module reg_pending_table holds the counter array. It provides the increment/decrement/saturate update, per-source hazard outputs and the overflow output.
- The register file array and output stage stay in the top module.

Test Plan:
- Reset mid-operation: issue with dst r5, assert reset_i asynchronously. Expect out_valid_o=0 immediately, pending[r5]=0 afterwards, and an issue reading r5 accepted in the next cycle.
- RAW stall: issue dst r3, then issue reading r3. Expect issue_ready_o=0 until wb r3=0xDEAD. On the wb cycle expect ready=1 and the next-cycle operand=0xDEAD via bypass.
- Count depth: PEND_W=2, three issues with dst r7, then a fourth. Expect the fourth stalled. One wb r7 releases it; the count returns to 3.
- Zero/imm: rd_zero_i=1 with addr 0 while r0=0x55 and pending → operand 0, no stall. rd_imm_i with addr 17 → operand 17.
- Dual wb collision: wb0 r9=0x1 and wb1 r9=0x2 with pending[r9]=2. Expect r9=0x2 and count 0. A stray wb r10 with count 0 sets wb_err_o=1.
- Backpressure: out_ready_i=0 with a valid bundle. Expect issue_ready_o=0 and operand_o, tag_o stable for 4 cycles. out_ready_i=1 with a new accept gives back-to-back valids.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and types for the register file / scoreboard block.
//   DEF_*      : default widths used by regfile_scoreboard parameters
//   pend_t     : pending-count type at the default counter width
//   opsel_e    : per-source operand select (immediate, zero, bypass, file)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_PEND_W = 2;
    localparam int DEF_TAG_W  = 32;

    typedef logic [DEF_PEND_W-1:0] pend_t;

    // Encoding order matches the operand priority: IMM beats ZERO beats
    // BYPASS beats FILE.
    typedef enum logic [1:0] {
        OPSEL_IMM    = 2'd0,
        OPSEL_ZERO   = 2'd1,
        OPSEL_BYPASS = 2'd2,
        OPSEL_FILE   = 2'd3
    } opsel_e;

endpackage

// File: rtl/reg_pending_table.sv
// -----------------------------------------------------------------------------
// reg_pending_table
// Per-register count of writebacks still in flight.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_accept         : instruction issued this cycle (reservations commit)
//   i_dst_en/addr    : destination reservations of the presented instruction
//   i_wb_en/addr     : writeback strobes (decrement, every cycle)
//   i_src_chk/addr   : sources that need a hazard check
//   o_src_hazard     : per-source RAW hazard (same-cycle bypass excluded)
//   o_overflow       : a reservation would exceed the counter range
//   o_wb_stray       : a writeback targets a register whose count is 0
// -----------------------------------------------------------------------------
module reg_pending_table #(
    parameter int REG_W    = 5,
    parameter int NUM_REGS = 2**REG_W,
    parameter int NUM_RD   = 3,
    parameter int NUM_DST  = 2,
    parameter int NUM_WB   = 2,
    parameter int PEND_W   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_accept,
    input  logic [NUM_DST-1:0]       i_dst_en,
    input  logic [NUM_DST*REG_W-1:0] i_dst_addr,
    input  logic [NUM_WB-1:0]        i_wb_en,
    input  logic [NUM_WB*REG_W-1:0]  i_wb_addr,
    input  logic [NUM_RD-1:0]        i_src_chk,
    input  logic [NUM_RD*REG_W-1:0]  i_src_addr,
    output logic [NUM_RD-1:0]        o_src_hazard,
    output logic                     o_overflow,
    output logic                     o_wb_stray
);

    localparam int PEND_MAX = 2**PEND_W - 1;

    logic [PEND_W-1:0] r_pend     [NUM_REGS];
    logic [PEND_W-1:0] w_pend_nxt [NUM_REGS];
    int                w_dst_cnt  [NUM_REGS];
    int                w_wb_cnt   [NUM_REGS];
    int                w_sum;
    logic [REG_W-1:0]  w_a;

    // NOTE: every signal written here gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        o_src_hazard = '0;
        o_overflow   = 1'b0;
        o_wb_stray   = 1'b0;
        w_sum        = 0;
        w_a          = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_dst_cnt[r] = 0;
            w_wb_cnt[r]  = 0;
        end

        // Per-register tallies of reservations and writebacks this cycle.
        for (int d = 0; d < NUM_DST; d++) begin
            if (i_dst_en[d]) begin
                w_a = i_dst_addr[d*REG_W +: REG_W];
                w_dst_cnt[w_a] = w_dst_cnt[w_a] + 1;
            end
        end
        for (int w = 0; w < NUM_WB; w++) begin
            if (i_wb_en[w]) begin
                w_a = i_wb_addr[w*REG_W +: REG_W];
                w_wb_cnt[w_a] = w_wb_cnt[w_a] + 1;
                if (r_pend[w_a] == '0) begin
                    o_wb_stray = 1'b1;
                end
            end
        end

        // Overflow is judged on the presented instruction, accepted or not,
        // because it feeds the ready that decides acceptance.
        for (int d = 0; d < NUM_DST; d++) begin
            if (i_dst_en[d]) begin
                w_a   = i_dst_addr[d*REG_W +: REG_W];
                w_sum = int'(r_pend[w_a]) + w_dst_cnt[w_a] - w_wb_cnt[w_a];
                if (w_sum > PEND_MAX) begin
                    o_overflow = 1'b1;
                end
            end
        end

        // A single outstanding write that lands this cycle is bypassed,
        // not stalled; any deeper count still stalls.
        for (int p = 0; p < NUM_RD; p++) begin
            w_a = i_src_addr[p*REG_W +: REG_W];
            if (i_src_chk[p] && (r_pend[w_a] != '0) &&
                !((r_pend[w_a] == PEND_W'(1)) && (w_wb_cnt[w_a] != 0))) begin
                o_src_hazard[p] = 1'b1;
            end
        end

        for (int r = 0; r < NUM_REGS; r++) begin
            w_sum = int'(r_pend[r]) - w_wb_cnt[r];
            if (i_accept) begin
                w_sum = w_sum + w_dst_cnt[r];
            end
            // Stray writebacks must not drive the count negative.
            if (w_sum < 0) begin
                w_sum = 0;
            end
            w_pend_nxt[r] = PEND_W'(w_sum);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pend[r] <= w_pend_nxt[r];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Multi-port GPR file with a counting pending-writeback scoreboard, same-cycle
// writeback bypass and a registered valid/ready output stage.
//   clock_i, reset_i      : clock, asynchronous active-high reset
//   issue_valid_i/ready_o : decode handshake; ready is combinational
//   rd_en/addr/zero/imm_i : source operand requests
//   dst_en/addr_i         : destination reservations
//   tag_i                 : opaque pass-through bundle
//   out_valid_o/ready_i   : output handshake
//   operand_o ... tag_o   : registered operand bundle
//   wb_en/addr/data_i     : writeback ports, applied every cycle
//   wb_err_o              : sticky stray-writeback flag
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_W    = DEF_REG_W,
    parameter int NUM_REGS = 2**REG_W,
    parameter int NUM_RD   = 3,
    parameter int NUM_DST  = 2,
    parameter int NUM_WB   = 2,
    parameter int PEND_W   = DEF_PEND_W,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*REG_W-1:0]  rd_addr_i,
    input  logic [NUM_RD-1:0]        rd_zero_i,
    input  logic [NUM_RD-1:0]        rd_imm_i,
    input  logic [NUM_DST-1:0]       dst_en_i,
    input  logic [NUM_DST*REG_W-1:0] dst_addr_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_RD*DATA_W-1:0] operand_o,
    output logic [NUM_RD-1:0]        operand_en_o,
    output logic [NUM_DST-1:0]       dst_en_o,
    output logic [NUM_DST*REG_W-1:0] dst_addr_o,
    output logic [TAG_W-1:0]         tag_o,
    input  logic [NUM_WB-1:0]        wb_en_i,
    input  logic [NUM_WB*REG_W-1:0]  wb_addr_i,
    input  logic [NUM_WB*DATA_W-1:0] wb_data_i,
    output logic                     wb_err_o
);

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic                     r_out_valid;
    logic [NUM_RD*DATA_W-1:0] r_operand;
    logic [NUM_RD-1:0]        r_operand_en;
    logic [NUM_DST-1:0]       r_dst_en;
    logic [NUM_DST*REG_W-1:0] r_dst_addr;
    logic [TAG_W-1:0]         r_tag;
    logic                     r_wb_err;

    logic [NUM_RD-1:0]        w_src_chk;
    logic [NUM_RD-1:0]        w_src_hazard;
    logic                     w_overflow;
    logic                     w_wb_stray;
    logic                     w_accept;
    opsel_e                   w_sel [NUM_RD];
    logic [DATA_W-1:0]        w_byp [NUM_RD];
    logic [NUM_RD-1:0]        w_hit;
    logic [NUM_RD*DATA_W-1:0] w_operand;
    logic [REG_W-1:0]         w_a;

    // Zero-semantics and immediates bypass the scoreboard entirely.
    always_comb begin
        w_src_chk = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_src_chk[p] = rd_en_i[p] & ~rd_imm_i[p] &
                           ~(rd_zero_i[p] & (rd_addr_i[p*REG_W +: REG_W] == '0));
        end
    end

    reg_pending_table #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_DST  (NUM_DST),
        .NUM_WB   (NUM_WB),
        .PEND_W   (PEND_W)
    ) u_pending (
        .i_clk        (clock_i),
        .i_rst        (reset_i),
        .i_accept     (w_accept),
        .i_dst_en     (dst_en_i),
        .i_dst_addr   (dst_addr_i),
        .i_wb_en      (wb_en_i),
        .i_wb_addr    (wb_addr_i),
        .i_src_chk    (w_src_chk),
        .i_src_addr   (rd_addr_i),
        .o_src_hazard (w_src_hazard),
        .o_overflow   (w_overflow),
        .o_wb_stray   (w_wb_stray)
    );

    assign issue_ready_o = ~|w_src_hazard & ~w_overflow & (~r_out_valid | out_ready_i);
    assign w_accept      = issue_valid_i & issue_ready_o;

    // Operand resolution. Sources read the pre-issue file/bypass value, so a
    // source naming its own instruction's destination sees the old data.
    always_comb begin
        w_operand = '0;
        w_hit     = '0;
        w_a       = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_sel[p] = OPSEL_FILE;
            w_byp[p] = '0;
        end
        for (int p = 0; p < NUM_RD; p++) begin
            w_a = rd_addr_i[p*REG_W +: REG_W];
            // Ascending scan: the highest-index matching port wins.
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_en_i[w] && (wb_addr_i[w*REG_W +: REG_W] == w_a)) begin
                    w_hit[p] = 1'b1;
                    w_byp[p] = wb_data_i[w*DATA_W +: DATA_W];
                end
            end
            if (rd_imm_i[p]) begin
                w_sel[p] = OPSEL_IMM;
            end else if (rd_zero_i[p] && (w_a == '0)) begin
                w_sel[p] = OPSEL_ZERO;
            end else if (w_hit[p]) begin
                w_sel[p] = OPSEL_BYPASS;
            end else begin
                w_sel[p] = OPSEL_FILE;
            end
            case (w_sel[p])
                OPSEL_IMM:    w_operand[p*DATA_W +: DATA_W] = {{(DATA_W-REG_W){1'b0}}, w_a};
                OPSEL_ZERO:   w_operand[p*DATA_W +: DATA_W] = '0;
                OPSEL_BYPASS: w_operand[p*DATA_W +: DATA_W] = w_byp[p];
                default:      w_operand[p*DATA_W +: DATA_W] = r_regs[w_a];
            endcase
        end
    end

    // NOTE: the register array is cleared on reset because architectural
    // state must read zero afterwards; this makes it flops, not a RAM macro.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            // Later loop iterations override earlier ones: higher port wins.
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_en_i[w]) begin
                    r_regs[wb_addr_i[w*REG_W +: REG_W]] <= wb_data_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output stage: loads on accept, otherwise holds; valid drops only when
    // the held bundle is consumed with nothing new behind it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_out_valid  <= 1'b0;
            r_operand    <= '0;
            r_operand_en <= '0;
            r_dst_en     <= '0;
            r_dst_addr   <= '0;
            r_tag        <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_operand    <= w_operand;
            r_operand_en <= rd_en_i;
            r_dst_en     <= dst_en_i;
            r_dst_addr   <= dst_addr_i;
            r_tag        <= tag_i;
        end else if (out_ready_i) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wb_err <= 1'b0;
        end else if (w_wb_stray) begin
            r_wb_err <= 1'b1;
        end
    end

    assign out_valid_o  = r_out_valid;
    assign operand_o    = r_operand;
    assign operand_en_o = r_operand_en;
    assign dst_en_o     = r_dst_en;
    assign dst_addr_o   = r_dst_addr;
    assign tag_o        = r_tag;
    assign wb_err_o     = r_wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed stimulus for regfile_scoreboard with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 2 units later, registered outputs 1 unit after the edge.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int DATA_W  = 64;
    localparam int REG_W   = 5;
    localparam int NUM_RD  = 3;
    localparam int NUM_DST = 2;
    localparam int NUM_WB  = 2;
    localparam int TAG_W   = 32;

    logic                     clock_i = 1'b0;
    logic                     reset_i;
    logic                     issue_valid_i;
    logic                     issue_ready_o;
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*REG_W-1:0]  rd_addr_i;
    logic [NUM_RD-1:0]        rd_zero_i;
    logic [NUM_RD-1:0]        rd_imm_i;
    logic [NUM_DST-1:0]       dst_en_i;
    logic [NUM_DST*REG_W-1:0] dst_addr_i;
    logic [TAG_W-1:0]         tag_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [NUM_RD*DATA_W-1:0] operand_o;
    logic [NUM_RD-1:0]        operand_en_o;
    logic [NUM_DST-1:0]       dst_en_o;
    logic [NUM_DST*REG_W-1:0] dst_addr_o;
    logic [TAG_W-1:0]         tag_o;
    logic [NUM_WB-1:0]        wb_en_i;
    logic [NUM_WB*REG_W-1:0]  wb_addr_i;
    logic [NUM_WB*DATA_W-1:0] wb_data_i;
    logic                     wb_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_scoreboard dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_zero_i     (rd_zero_i),
        .rd_imm_i      (rd_imm_i),
        .dst_en_i      (dst_en_i),
        .dst_addr_i    (dst_addr_i),
        .tag_i         (tag_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .operand_o     (operand_o),
        .operand_en_o  (operand_en_o),
        .dst_en_o      (dst_en_o),
        .dst_addr_o    (dst_addr_o),
        .tag_o         (tag_o),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .wb_err_o      (wb_err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        issue_valid_i = 1'b0;
        rd_en_i       = '0;
        rd_addr_i     = '0;
        rd_zero_i     = '0;
        rd_imm_i      = '0;
        dst_en_i      = '0;
        dst_addr_i    = '0;
        tag_i         = '0;
        out_ready_i   = 1'b1;
        wb_en_i       = '0;
        wb_addr_i     = '0;
        wb_data_i     = '0;
    endtask

    task automatic src(input int p, input logic [REG_W-1:0] addr, input logic zero, input logic imm);
        rd_en_i[p]                 = 1'b1;
        rd_addr_i[p*REG_W +: REG_W] = addr;
        rd_zero_i[p]               = zero;
        rd_imm_i[p]                = imm;
    endtask

    task automatic dst(input int d, input logic [REG_W-1:0] addr);
        dst_en_i[d]                  = 1'b1;
        dst_addr_i[d*REG_W +: REG_W] = addr;
    endtask

    task automatic wb(input int w, input logic [REG_W-1:0] addr, input logic [DATA_W-1:0] data);
        wb_en_i[w]                   = 1'b1;
        wb_addr_i[w*REG_W +: REG_W]  = addr;
        wb_data_i[w*DATA_W +: DATA_W] = data;
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    function automatic logic [63:0] opnd(input int p);
        return operand_o[p*DATA_W +: DATA_W];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        reset_i = 1'b1;
        #12;
        check("rst_valid",   64'(out_valid_o),   64'd0);
        check("rst_ready",   64'(issue_ready_o), 64'd1);
        check("rst_wb_err",  64'(wb_err_o),      64'd0);
        check("rst_tag",     64'(tag_o),         64'd0);
        check("rst_operand", opnd(0),            64'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        step();

        // Reset mid-operation: reservation of r5 is wiped asynchronously.
        issue_valid_i = 1'b1;
        dst(0, 5'd5);
        tag_i = 32'hA5;
        #2 check("A_ready", 64'(issue_ready_o), 64'd1);
        step();
        check("A_valid",    64'(out_valid_o), 64'd1);
        check("A_tag",      64'(tag_o),       64'hA5);
        check("A_dst_en",   64'(dst_en_o),    64'h1);
        check("A_dst_addr", 64'(dst_addr_o),  64'h5);
        clear_in();
        reset_i = 1'b1;
        #1 check("A_async_valid", 64'(out_valid_o), 64'd0);
        check("A_async_tag", 64'(tag_o), 64'd0);
        #1 reset_i = 1'b0;
        issue_valid_i = 1'b1;
        src(0, 5'd5, 1'b0, 1'b0);
        tag_i = 32'h5A;
        #2 check("A_r5_free", 64'(issue_ready_o), 64'd1);
        step();
        check("A_r5_valid",   64'(out_valid_o),  64'd1);
        check("A_r5_operand", opnd(0),           64'd0);
        check("A_operand_en", 64'(operand_en_o), 64'h1);

        // RAW stall on r3, released by a bypassed writeback.
        clear_in();
        issue_valid_i = 1'b1;
        dst(0, 5'd3);
        #2 check("B_dst_ready", 64'(issue_ready_o), 64'd1);
        step();
        clear_in();
        issue_valid_i = 1'b1;
        src(0, 5'd3, 1'b0, 1'b0);
        #2 check("B_stall", 64'(issue_ready_o), 64'd0);
        step();
        check("B_stall2",      64'(issue_ready_o), 64'd0);
        check("B_valid_drain", 64'(out_valid_o),   64'd0);
        wb(0, 5'd3, 64'hDEAD);
        #2 check("B_wb_ready", 64'(issue_ready_o), 64'd1);
        step();
        check("B_valid",  64'(out_valid_o), 64'd1);
        check("B_bypass", opnd(0),          64'hDEAD);
        clear_in();
        issue_valid_i = 1'b1;
        src(0, 5'd3, 1'b0, 1'b0);
        #2 check("B_file_ready", 64'(issue_ready_o), 64'd1);
        step();
        check("B_file", opnd(0), 64'hDEAD);

        // Count depth: three reservations of r7 fill a 2-bit counter.
        clear_in();
        issue_valid_i = 1'b1;
        dst(0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            #2 check($sformatf("C_ready%0d", i), 64'(issue_ready_o), 64'd1);
            step();
        end
        #2 check("C_full", 64'(issue_ready_o), 64'd0);
        step();
        check("C_full2", 64'(issue_ready_o), 64'd0);
        wb(0, 5'd7, 64'h77);
        #2 check("C_release", 64'(issue_ready_o), 64'd1);
        step();
        clear_in();
        issue_valid_i = 1'b1;
        dst(0, 5'd7);
        #2 check("C_count3", 64'(issue_ready_o), 64'd0);
        check("C_no_err", 64'(wb_err_o), 64'd0);

        // Zero / immediate semantics with r0 = 0x55 and pending.
        clear_in();
        issue_valid_i = 1'b1;
        dst(0, 5'd0);
        step();
        clear_in();
        wb(0, 5'd0, 64'h55);
        step();
        clear_in();
        issue_valid_i = 1'b1;
        dst(0, 5'd0);
        step();
        clear_in();
        issue_valid_i = 1'b1;
        src(2, 5'd0, 1'b0, 1'b0);
        #2 check("D_r0_hazard", 64'(issue_ready_o), 64'd0);
        clear_in();
        issue_valid_i = 1'b1;
        src(0, 5'd0, 1'b1, 1'b0);
        src(1, 5'd17, 1'b0, 1'b1);
        tag_i = 32'hD;
        #2 check("D_ready", 64'(issue_ready_o), 64'd1);
        step();
        check("D_zero", opnd(0), 64'd0);
        check("D_imm",  opnd(1), 64'd17);

        // Dual writeback collision on r9, then a stray writeback to r10.
        clear_in();
        issue_valid_i = 1'b1;
        dst(0, 5'd9);
        dst(1, 5'd9);
        #2 check("E_ready", 64'(issue_ready_o), 64'd1);
        step();
        clear_in();
        wb(0, 5'd9, 64'h1);
        wb(1, 5'd9, 64'h2);
        step();
        check("E_no_err", 64'(wb_err_o), 64'd0);
        clear_in();
        issue_valid_i = 1'b1;
        src(0, 5'd9, 1'b0, 1'b0);
        #2 check("E_count0", 64'(issue_ready_o), 64'd1);
        step();
        check("E_r9", opnd(0), 64'h2);
        clear_in();
        wb(0, 5'd10, 64'hBAD);
        #2 check("E_err_pre", 64'(wb_err_o), 64'd0);
        step();
        check("E_err", 64'(wb_err_o), 64'd1);
        clear_in();
        step();
        step();
        check("E_err_sticky", 64'(wb_err_o), 64'd1);

        // Backpressure: held bundle stays stable, then back-to-back accepts.
        clear_in();
        out_ready_i   = 1'b0;
        issue_valid_i = 1'b1;
        src(0, 5'd9, 1'b0, 1'b0);
        tag_i = 32'hB00F;
        #2 check("F_ready", 64'(issue_ready_o), 64'd1);
        step();
        clear_in();
        out_ready_i   = 1'b0;
        issue_valid_i = 1'b1;
        src(0, 5'd5, 1'b0, 1'b1);
        tag_i = 32'hC0DE;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("F_hold_ready%0d", i), 64'(issue_ready_o), 64'd0);
            check($sformatf("F_hold_valid%0d", i), 64'(out_valid_o),   64'd1);
            check($sformatf("F_hold_opnd%0d", i),  opnd(0),            64'h2);
            check($sformatf("F_hold_tag%0d", i),   64'(tag_o),         64'hB00F);
            step();
        end
        out_ready_i = 1'b1;
        #2 check("F_resume", 64'(issue_ready_o), 64'd1);
        step();
        check("F_b2b_valid1", 64'(out_valid_o), 64'd1);
        check("F_b2b_tag1",   64'(tag_o),       64'hC0DE);
        check("F_b2b_opnd1",  opnd(0),          64'h5);
        tag_i = 32'hD00D;
        #2 check("F_ready2", 64'(issue_ready_o), 64'd1);
        step();
        check("F_b2b_valid2", 64'(out_valid_o), 64'd1);
        check("F_b2b_tag2",   64'(tag_o),       64'hD00D);
        clear_in();
        step();
        check("F_drain", 64'(out_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
